ex_mem_stage: RTL and testbench

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

---
 rtl/ex_mem_stage_if.sv | 47 ++++
 rtl/ex_mem_stage.sv | 113 +++++++++++
 tb/tb_ex_mem_stage.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_stage_if.sv
// EX/MEM stage bundle: execute-side inputs, data-memory bus and memory-stage outputs.
// The slave modport is the stage itself; the master modport is its environment.
interface ex_mem_stage_if #(
    parameter int unsigned DW = 32
);
    logic          ValidE;
    logic          RegWriteE;
    logic          MemWriteE;
    logic          MemtoRegE;
    logic          PCSrcE;
    logic [DW-1:0] ALUResultE;
    logic [DW-1:0] WriteDataE;
    logic [3:0]    WA3E;

    logic          DReq;
    logic          DWe;
    logic [DW-1:0] DAddr;
    logic [DW-1:0] DWData;
    logic          DAck;
    logic [DW-1:0] DRData;

    logic          StallM;
    logic          ValidM;
    logic          RegWriteM;
    logic          MemtoRegM;
    logic          PCSrcM;
    logic [DW-1:0] ALUOutM;
    logic [DW-1:0] ReadDataM;
    logic [3:0]    WA3M;
    logic          MemTimeout;

    modport master (
        output ValidE, RegWriteE, MemWriteE, MemtoRegE, PCSrcE, ALUResultE, WriteDataE, WA3E,
        output DAck, DRData,
        input  DReq, DWe, DAddr, DWData,
        input  StallM, ValidM, RegWriteM, MemtoRegM, PCSrcM, ALUOutM, ReadDataM, WA3M,
        input  MemTimeout
    );

    modport slave (
        input  ValidE, RegWriteE, MemWriteE, MemtoRegE, PCSrcE, ALUResultE, WriteDataE, WA3E,
        input  DAck, DRData,
        output DReq, DWe, DAddr, DWData,
        output StallM, ValidM, RegWriteM, MemtoRegM, PCSrcM, ALUOutM, ReadDataM, WA3M,
        output MemTimeout
    );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with a blocking data-memory access FSM (IDLE/BUSY/DONE)
// and a bounded wait that aborts the access after TMO+1 unacknowledged cycles.
module ex_mem_stage #(
    parameter int unsigned DW  = 32,
    parameter int unsigned TMO = 15
) (
    input logic          i_clk,
    input logic          i_rst,
    ex_mem_stage_if.slave bus
);
    localparam int unsigned CW = (TMO < 1) ? 1 : $clog2(TMO + 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e        r_state;
    state_e        w_state_d;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_d;
    logic          r_abort;
    logic          w_abort_d;

    logic          r_valid;
    logic          r_reg_write;
    logic          r_mem_write;
    logic          r_memto_reg;
    logic          r_pc_src;
    logic [DW-1:0] r_alu_result;
    logic [DW-1:0] r_write_data;
    logic [3:0]    r_wa3;
    logic [DW-1:0] r_read_data;

    logic          w_busy;
    logic          w_load;
    logic          w_mem_op;
    logic          w_commit;

    always_comb begin
        w_busy    = (r_state == StBusy);
        w_load    = ~w_busy;
        // A load whose condition failed arrives with RegWriteE=0 and must not touch memory.
        w_mem_op  = bus.ValidE & (bus.MemWriteE | (bus.MemtoRegE & bus.RegWriteE));
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_abort_d = r_abort;
        case (r_state)
            StBusy: begin
                if (bus.DAck) begin
                    w_state_d = StDone;
                end else if (r_cnt == CW'(TMO)) begin
                    w_abort_d = 1'b1;
                    w_state_d = StDone;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_d = w_mem_op ? StBusy : StIdle;
                w_cnt_d   = '0;
                w_abort_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_abort      <= 1'b0;
            r_valid      <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_write  <= 1'b0;
            r_memto_reg  <= 1'b0;
            r_pc_src     <= 1'b0;
            r_alu_result <= '0;
            r_write_data <= '0;
            r_wa3        <= '0;
            r_read_data  <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_abort <= w_abort_d;
            if (w_load) begin
                r_valid      <= bus.ValidE;
                r_reg_write  <= bus.RegWriteE;
                r_mem_write  <= bus.MemWriteE;
                r_memto_reg  <= bus.MemtoRegE;
                r_pc_src     <= bus.PCSrcE;
                r_alu_result <= bus.ALUResultE;
                r_write_data <= bus.WriteDataE;
                r_wa3        <= bus.WA3E;
            end
            if (w_busy && bus.DAck) begin
                r_read_data <= bus.DRData;
            end
        end
    end

    assign w_commit       = r_valid & ~w_busy & ~r_abort;

    assign bus.DReq       = w_busy;
    assign bus.DWe        = w_busy & r_mem_write;
    assign bus.DAddr      = r_alu_result;
    assign bus.DWData     = r_write_data;
    assign bus.StallM     = w_busy;
    assign bus.ValidM     = r_valid;
    assign bus.RegWriteM  = r_reg_write & w_commit;
    assign bus.PCSrcM     = r_pc_src & w_commit;
    assign bus.MemtoRegM  = r_memto_reg;
    assign bus.ALUOutM    = r_alu_result;
    assign bus.WA3M       = r_wa3;
    assign bus.ReadDataM  = r_read_data;
    assign bus.MemTimeout = (r_state == StDone) & r_abort;
endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed and random instructions compared against
// a transaction-level model of stall length, bus contents and the committed result.
module tb_ex_mem_stage;
    localparam int unsigned DW  = 32;
    localparam int unsigned TMO = 15;

    typedef struct packed {
        logic          valid;
        logic          rw;
        logic          mw;
        logic          mtr;
        logic          ps;
        logic [DW-1:0] alu;
        logic [DW-1:0] wd;
        logic [3:0]    wa3;
    } instr_t;

    typedef struct packed {
        logic [7:0]    busy;
        logic          we;
        logic [DW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          bad;
        logic          unstable;
    } busy_t;

    typedef struct packed {
        logic          dreq;
        logic          stall;
        logic          valid;
        logic          rw;
        logic          mtr;
        logic          ps;
        logic [DW-1:0] aluout;
        logic [3:0]    wa3;
        logic [DW-1:0] rdata;
        logic          tmo;
    } out_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [DW-1:0] m_rdata;

    ex_mem_stage_if #(.DW(DW)) bus ();

    ex_mem_stage #(.DW(DW), .TMO(TMO)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic instr_t rand_instr();
        instr_t t;
        t.valid = 1'($urandom);
        t.rw    = 1'($urandom);
        t.mw    = 1'($urandom);
        t.mtr   = 1'($urandom);
        t.ps    = 1'($urandom);
        t.alu   = DW'($urandom);
        t.wd    = DW'($urandom);
        t.wa3   = 4'($urandom);
        return t;
    endfunction

    task automatic drive_e(input instr_t in);
        bus.ValidE     = in.valid;
        bus.RegWriteE  = in.rw;
        bus.MemWriteE  = in.mw;
        bus.MemtoRegE  = in.mtr;
        bus.PCSrcE     = in.ps;
        bus.ALUResultE = in.alu;
        bus.WriteDataE = in.wd;
        bus.WA3E       = in.wa3;
    endtask

    // Reference: memory ops wait until the ack or TMO+1 cycles, then commit unless aborted.
    task automatic model(input instr_t in, input int ack_at, input logic [DW-1:0] rd,
                         output busy_t eb, output out_t eo);
        bit mem;
        bit to;
        int n;
        mem = in.valid && (in.mw || (in.mtr && in.rw));
        to  = 1'b0;
        n   = 0;
        if (mem) begin
            if (ack_at >= 1 && ack_at <= int'(TMO) + 1) n = ack_at;
            else begin
                n  = int'(TMO) + 1;
                to = 1'b1;
            end
            if (!to) m_rdata = rd;
        end
        eb = '{busy: 8'(n), we: mem ? in.mw : 1'b0, addr: mem ? in.alu : '0,
               wdata: mem ? in.wd : '0, bad: 1'b0, unstable: 1'b0};
        eo = '{dreq: 1'b0, stall: 1'b0, valid: in.valid, rw: in.valid & in.rw & ~to,
               mtr: in.mtr, ps: in.valid & in.ps & ~to, aluout: in.alu, wa3: in.wa3,
               rdata: m_rdata, tmo: to};
    endtask

    // Issue one instruction at a negedge; observe every stall cycle and the M/DONE cycle.
    task automatic run_instr(input instr_t in, input int ack_at, input logic [DW-1:0] rd,
                             output busy_t ob, output out_t oo);
        int c;
        ob = '0;
        drive_e(in);
        bus.DAck   = 1'($urandom);
        bus.DRData = DW'($urandom);
        @(negedge clk);
        c = 0;
        while (bus.StallM === 1'b1 && c < int'(TMO) + 4) begin
            c++;
            if (c == 1) begin
                ob.we    = bus.DWe;
                ob.addr  = bus.DAddr;
                ob.wdata = bus.DWData;
            end else if (bus.DWe !== ob.we || bus.DAddr !== ob.addr || bus.DWData !== ob.wdata)
                ob.unstable = 1'b1;
            if (bus.DReq !== 1'b1 || bus.ValidM !== 1'b1 || bus.RegWriteM !== 1'b0 ||
                bus.PCSrcM !== 1'b0 || bus.MemTimeout !== 1'b0)
                ob.bad = 1'b1;
            bus.DAck   = (c == ack_at);
            bus.DRData = (c == ack_at) ? rd : DW'($urandom);
            drive_e(rand_instr());
            @(negedge clk);
        end
        ob.busy = 8'(c);
        oo = '{dreq: bus.DReq, stall: bus.StallM, valid: bus.ValidM, rw: bus.RegWriteM,
               mtr: bus.MemtoRegM, ps: bus.PCSrcM, aluout: bus.ALUOutM, wa3: bus.WA3M,
               rdata: bus.ReadDataM, tmo: bus.MemTimeout};
    endtask

    task automatic test_reset();
        logic [2*DW+12:0] got;
        rst = 1'b1;
        drive_e(rand_instr());
        bus.DAck   = 1'b1;
        bus.DRData = DW'($urandom);
        repeat (3) @(negedge clk);
        got = {bus.DReq, bus.DWe, bus.StallM, bus.ValidM, bus.RegWriteM, bus.PCSrcM,
               bus.MemtoRegM, bus.MemTimeout, bus.ALUOutM, bus.ReadDataM, bus.WA3M, 1'b0};
        n_checks++;
        if (got !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", got);
        end
        rst     = 1'b0;
        m_rdata = '0;
    endtask

    task automatic test_alu();
        instr_t in;
        busy_t  eb, ob;
        out_t   eo, oo;
        for (int i = 0; i < 7; i++) begin
            if (i == 0) in = '{valid: 1'b1, rw: 1'b1, mw: 1'b0, mtr: 1'b0, ps: 1'b0,
                               alu: 32'h0000_0010, wd: '0, wa3: 4'd3};
            else begin
                in = rand_instr();
                in.mw = 1'b0;
                if (in.rw) in.mtr = 1'b0;
            end
            model(in, 1, DW'($urandom), eb, eo);
            run_instr(in, 1, DW'($urandom), ob, oo);
            n_checks++;
            if (ob !== eb) begin
                n_fail++;
                $display("FAIL alu_%0d stall: got %h want %h", i, ob, eb);
            end
            n_checks++;
            if (oo !== eo) begin
                n_fail++;
                $display("FAIL alu_%0d result: got %h want %h", i, oo, eo);
            end
        end
    endtask

    task automatic test_mem_directed();
        instr_t in;
        busy_t  eb, ob;
        out_t   eo, oo;
        int     ack;
        logic [DW-1:0] rd;
        for (int i = 0; i < 3; i++) begin
            in = '{valid: 1'b1, rw: 1'b1, mw: 1'b0, mtr: 1'b1, ps: 1'b0,
                   alu: 32'h0000_0100, wd: 32'h1234_5678, wa3: 4'd7};
            ack = 3;
            rd  = 32'hDEAD_BEEF;
            if (i == 1) begin
                in.rw  = 1'b0;
                in.mtr = 1'b0;
                in.mw  = 1'b1;
                in.wd  = 32'hCAFE_0001;
                ack    = 1;
                rd     = 32'h5555_AAAA;
            end else if (i == 2) begin
                in.alu = 32'h0000_0200;
                ack    = 0;
            end
            model(in, ack, rd, eb, eo);
            run_instr(in, ack, rd, ob, oo);
            n_checks++;
            if (ob !== eb) begin
                n_fail++;
                $display("FAIL mem_%0d stall: got %h want %h", i, ob, eb);
            end
            n_checks++;
            if (oo !== eo) begin
                n_fail++;
                $display("FAIL mem_%0d result: got %h want %h", i, oo, eo);
            end
        end
    endtask

    task automatic test_back_to_back();
        instr_t in;
        busy_t  eb, ob;
        out_t   eo, oo;
        logic [DW-1:0] rd;
        for (int i = 0; i < 5; i++) begin
            in = rand_instr();
            in.valid = 1'b1;
            in.mw    = (i == 4);
            in.mtr   = 1'b1;
            in.rw    = (i != 0);
            rd = DW'($urandom);
            model(in, 2, rd, eb, eo);
            run_instr(in, 2, rd, ob, oo);
            n_checks++;
            if (ob !== eb) begin
                n_fail++;
                $display("FAIL b2b_%0d stall: got %h want %h", i, ob, eb);
            end
            n_checks++;
            if (oo !== eo) begin
                n_fail++;
                $display("FAIL b2b_%0d result: got %h want %h", i, oo, eo);
            end
        end
    endtask

    task automatic test_reset_mid_busy();
        instr_t in;
        logic [2:0]    got3;
        logic [DW+2:0] got;
        in = '{valid: 1'b1, rw: 1'b1, mw: 1'b0, mtr: 1'b1, ps: 1'b1,
               alu: 32'h0000_0300, wd: '0, wa3: 4'd9};
        drive_e(in);
        bus.DAck = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.StallM !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_busy_pre: StallM got %b want 1", bus.StallM);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1 got3 = {bus.DReq, bus.StallM, bus.ValidM};
        n_checks++;
        if (got3 !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_busy_async: {DReq,StallM,ValidM} got %b want 000", got3);
        end
        m_rdata = '0;
        @(negedge clk);
        rst = 1'b0;
        in.valid = 1'b0;
        drive_e(in);
        bus.DAck   = 1'b1;
        bus.DRData = DW'($urandom);
        repeat (2) @(negedge clk);
        got = {bus.DReq, bus.StallM, bus.ValidM, bus.ReadDataM};
        n_checks++;
        if (got !== {3'b000, m_rdata}) begin
            n_fail++;
            $display("FAIL rst_busy_late_ack: got %h want %h", got, {3'b000, m_rdata});
        end
        bus.DAck = 1'b0;
    endtask

    task automatic test_random();
        instr_t in;
        busy_t  eb, ob;
        out_t   eo, oo;
        int     ack;
        logic [DW-1:0] rd;
        for (int i = 0; i < 60; i++) begin
            in = rand_instr();
            if ($urandom_range(0, 1) == 1) in.valid = 1'b1;
            ack = $urandom_range(0, TMO + 2);
            rd  = DW'($urandom);
            model(in, ack, rd, eb, eo);
            run_instr(in, ack, rd, ob, oo);
            n_checks++;
            if (ob !== eb) begin
                n_fail++;
                $display("FAIL rand_%0d stall: got %h want %h", i, ob, eb);
            end
            n_checks++;
            if (oo !== eo) begin
                n_fail++;
                $display("FAIL rand_%0d result: got %h want %h", i, oo, eo);
            end
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        m_rdata    = '0;
        rst        = 1'b1;
        bus.DAck   = 1'b0;
        bus.DRData = '0;
        drive_e('0);
        @(negedge clk);
        test_reset();
        test_alu();
        test_mem_directed();
        test_back_to_back();
        test_reset_mid_busy();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
